// File: rtl/fpu_wb_sched.sv
// Writeback scheduler for the FPU register file: round-robin arbitration of result
// streams onto the single write port, plus a busy scoreboard for RAW/WAW issue stalls.
module fpu_wb_sched #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 6,
  parameter int unsigned DW   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][AW-1:0]   req_rd,
  input  logic [NREQ-1:0][DW-1:0]   req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      regW_en,
  output logic [AW-1:0]             rsW,
  output logic [DW-1:0]             dataW,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_rd,
  input  logic [AW-1:0]             issue_rs1,
  input  logic [AW-1:0]             issue_rs2,
  input  logic [AW-1:0]             issue_rs3,
  output logic                      issue_stall,
  output logic [(2**AW)-1:0]        busy,
  output logic                      wb_err
);

  localparam int unsigned NREG = 2**AW;
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   last_q, last_d;
  logic            regw_en_q, regw_en_d;
  logic [AW-1:0]   rsw_q, rsw_d;
  logic [DW-1:0]   dataw_q, dataw_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            wb_err_q, wb_err_d;

  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic [AW-1:0]   gnt_rd;
  logic [DW-1:0]   gnt_data;
  logic            wb_fire;
  logic            issue_go;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_vld   = 1'b0;
    gnt_idx   = last_q;
    req_ready = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = (int'(last_q) + k) % int'(NREQ);
      if (!gnt_vld && req_valid[IW'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_rd   = req_rd[gnt_idx];
  assign gnt_data = req_data[gnt_idx];
  assign wb_fire  = gnt_vld && (gnt_rd != '0);

  // Hazard check depends only on issue inputs and the registered scoreboard.
  assign issue_stall = issue_valid && (busy_q[issue_rs1] || busy_q[issue_rs2] ||
                                       busy_q[issue_rs3] || busy_q[issue_rd]);
  assign issue_go    = issue_valid && !issue_stall && (issue_rd != '0);

  always_comb begin
    last_d    = last_q;
    regw_en_d = wb_fire;
    rsw_d     = rsw_q;
    dataw_d   = dataw_q;
    busy_d    = busy_q;
    wb_err_d  = wb_err_q;
    if (gnt_vld) last_d = gnt_idx;
    if (wb_fire) begin
      rsw_d          = gnt_rd;
      dataw_d        = gnt_data;
      busy_d[gnt_rd] = 1'b0;
      if (!busy_q[gnt_rd]) wb_err_d = 1'b1;
    end
    // A new issue to the register being written back keeps it busy.
    if (issue_go) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q    <= IW'(NREQ - 1);
      regw_en_q <= 1'b0;
      rsw_q     <= '0;
      dataw_q   <= '0;
      busy_q    <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      last_q    <= last_d;
      regw_en_q <= regw_en_d;
      rsw_q     <= rsw_d;
      dataw_q   <= dataw_d;
      busy_q    <= busy_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign regW_en = regw_en_q;
  assign rsW     = rsw_q;
  assign dataW   = dataw_q;
  assign busy    = busy_q;
  assign wb_err  = wb_err_q;

endmodule
